// File: rtl/cblock_cfg_loader.sv
// Serial configuration loader for a row of connection blocks.
// It shifts in a payload followed by an even-parity bit and commits the payload only when the parity matches.
module cblock_cfg_loader #(
  parameter int BITS_W  = 18,
  parameter int NUM_BLK = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      cfg_bit_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [NUM_BLK-1:0]        wr_en_o,
  output logic [NUM_BLK*BITS_W-1:0] bits_o
);

  localparam int N  = NUM_BLK * BITS_W;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(N);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, COMMIT} state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                par_q, par_d;
  logic                mis_q, mis_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [NUM_BLK-1:0]  wr_en_q, wr_en_d;
  logic [N-1:0]        bits_q, bits_d;
  logic                xfer;

  assign cfg_ready_o = (state_q == SHIFT) || (state_q == PARITY);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign wr_en_o     = wr_en_q;
  assign bits_o      = bits_q;
  assign xfer        = cfg_valid_i && cfg_ready_o;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    mis_d   = mis_q;
    done_d  = done_q;
    err_d   = err_q;
    wr_en_d = wr_en_q;
    bits_d  = bits_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
          par_d   = 1'b0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wr_en_d = '1;
        end
      end
      SHIFT: begin
        // A restart takes priority over a bit offered in the same cycle.
        if (start_i) begin
          shift_d = '0;
          cnt_d   = '0;
          par_d   = 1'b0;
        end else if (xfer) begin
          shift_d = {shift_q[N-2:0], cfg_bit_i};
          par_d   = par_q ^ cfg_bit_i;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == LAST_CNT) state_d = PARITY;
        end
      end
      PARITY: begin
        if (start_i) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
          par_d   = 1'b0;
        end else if (xfer) begin
          mis_d   = cfg_bit_i ^ par_q;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (!mis_q) begin
          bits_d  = shift_q;
          wr_en_d = '0;
          done_d  = 1'b1;
        end else begin
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      mis_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_en_q <= '1;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      mis_q   <= mis_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wr_en_q <= wr_en_d;
      bits_q  <= bits_d;
    end
  end

endmodule

// File: tb/tb_cblock_cfg_loader.sv
// Bench for cblock_cfg_loader: a frame-level model checked against the DUT every cycle,
// plus directed frames whose results are also pinned to hand-computed constants.
module tb_cblock_cfg_loader;

  localparam int BITS_W  = 18;
  localparam int NUM_BLK = 2;
  localparam int N       = BITS_W * NUM_BLK;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start_i;
  logic               cfg_bit_i;
  logic               cfg_valid_i;
  logic               cfg_ready_o;
  logic               busy_o;
  logic               done_o;
  logic               err_o;
  logic [NUM_BLK-1:0] wr_en_o;
  logic [N-1:0]       bits_o;

  int errors = 0;
  int checks = 0;
  int xferCount = 0;

  // Frame-level model: accepted bits collected in a queue, resolved one cycle after the parity bit.
  bit               modelLive = 1'b0;
  bit               mActive, mPend;
  bit               mQ[$];
  logic [N-1:0]     mBits;
  logic [NUM_BLK-1:0] mWr;
  logic             mDone, mErr;

  cblock_cfg_loader #(.BITS_W(BITS_W), .NUM_BLK(NUM_BLK)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cfg_bit_i(cfg_bit_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .wr_en_o(wr_en_o), .bits_o(bits_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      modelLive = 1'b1;
      mActive = 1'b0;
      mPend = 1'b0;
      mQ.delete();
      mBits = '0;
      mWr = '1;
      mDone = 1'b0;
      mErr = 1'b0;
    end else if (mPend) begin
      bit p;
      logic [N-1:0] v;
      p = 1'b0;
      v = '0;
      for (int i = 0; i < N; i++) begin
        p ^= mQ[i];
        v[N-1-i] = mQ[i];
      end
      if (p == mQ[N]) begin
        mBits = v;
        mWr = '0;
        mDone = 1'b1;
      end else begin
        mErr = 1'b1;
      end
      mActive = 1'b0;
      mPend = 1'b0;
    end else if (start_i) begin
      mActive = 1'b1;
      mQ.delete();
      mDone = 1'b0;
      mErr = 1'b0;
      mWr = '1;
    end else if (mActive && cfg_valid_i) begin
      mQ.push_back(cfg_bit_i);
      if (mQ.size() == N + 1) mPend = 1'b1;
    end
  end

  // Every cycle after reset has been seen, the DUT must agree with the model.
  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("cfg_ready_o", 64'(cfg_ready_o), 64'(mActive && !mPend));
      checkOutput("busy_o", 64'(busy_o), 64'(mActive));
      checkOutput("done_o", 64'(done_o), 64'(mDone));
      checkOutput("err_o", 64'(err_o), 64'(mErr));
      checkOutput("wr_en_o", 64'(wr_en_o), 64'(mWr));
      checkOutput("bits_o", 64'(bits_o), 64'(mBits));
      if (cfg_valid_i && cfg_ready_o) xferCount++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Sends up to stopAfter bits of payload+parity; gaps alternates valid 0/1.
  task automatic applyStimulus(input logic [N-1:0] payload, input logic par, input bit gaps, input int stopAfter);
    int idx = 0;
    int cyc = 0;
    bit xfer;
    while (idx < N + 1 && idx < stopAfter) begin
      cfg_valid_i = gaps ? cyc[0] : 1'b1;
      cfg_bit_i = (idx < N) ? payload[N-1-idx] : par;
      xfer = cfg_valid_i && cfg_ready_o;
      tick();
      cyc++;
      if (xfer) idx++;
      if (cyc > 500) begin
        checkOutput("frame_timeout", 64'(idx), 64'(N + 1));
        break;
      end
    end
    cfg_valid_i = 1'b0;
    cfg_bit_i = 1'b0;
  endtask

  initial begin
    logic [N-1:0] cleanFrame;
    logic [N-1:0] onesFrame;
    int xferStart;
    cleanFrame = 36'h060080044;
    onesFrame  = 36'hFFFFFFFFF;

    rst_n = 1'b0;
    start_i = 1'b1;
    cfg_valid_i = 1'b1;
    cfg_bit_i = 1'b1;
    tick();
    tick();
    checkOutput("reset_wr_en", 64'(wr_en_o), 64'h3);
    checkOutput("reset_bits", 64'(bits_o), 64'h0);
    checkOutput("reset_ready", 64'(cfg_ready_o), 64'h0);
    checkOutput("reset_done", 64'(done_o), 64'h0);
    checkOutput("reset_err", 64'(err_o), 64'h0);
    rst_n = 1'b1;
    start_i = 1'b0;
    cfg_valid_i = 1'b0;
    cfg_bit_i = 1'b0;
    tick();

    pulseStart();
    applyStimulus(cleanFrame, 1'b1, 1'b0, N + 1);
    tick();
    tick();
    checkOutput("clean_bits_hi", 64'(bits_o[35:18]), 64'h01802);
    checkOutput("clean_bits_lo", 64'(bits_o[17:0]), 64'h00044);
    checkOutput("clean_wr_en", 64'(wr_en_o), 64'h0);
    checkOutput("clean_done", 64'(done_o), 64'h1);
    checkOutput("clean_busy", 64'(busy_o), 64'h0);
    checkOutput("model_clean_bits", 64'(mBits), 64'h060080044);

    pulseStart();
    applyStimulus(cleanFrame, 1'b0, 1'b0, N + 1);
    tick();
    tick();
    checkOutput("perr_err", 64'(err_o), 64'h1);
    checkOutput("perr_done", 64'(done_o), 64'h0);
    checkOutput("perr_wr_en", 64'(wr_en_o), 64'h3);
    checkOutput("perr_bits", 64'(bits_o), 64'h060080044);
    checkOutput("model_perr_err", 64'(mErr), 64'h1);

    xferStart = xferCount;
    pulseStart();
    applyStimulus(cleanFrame, 1'b1, 1'b1, N + 1);
    tick();
    tick();
    checkOutput("gap_transfers", 64'(xferCount - xferStart), 64'd37);
    checkOutput("gap_bits", 64'(bits_o), 64'h060080044);
    checkOutput("gap_wr_en", 64'(wr_en_o), 64'h0);
    checkOutput("gap_done", 64'(done_o), 64'h1);

    pulseStart();
    applyStimulus(cleanFrame, 1'b1, 1'b0, 20);
    pulseStart();
    applyStimulus(onesFrame, 1'b0, 1'b0, N + 1);
    tick();
    tick();
    checkOutput("abort_bits", 64'(bits_o), 64'hFFFFFFFFF);
    checkOutput("abort_wr_en", 64'(wr_en_o), 64'h0);
    checkOutput("abort_done", 64'(done_o), 64'h1);
    checkOutput("model_abort_bits", 64'(mBits), 64'hFFFFFFFFF);

    pulseStart();
    applyStimulus(cleanFrame, 1'b1, 1'b0, 10);
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_bits", 64'(bits_o), 64'h0);
    checkOutput("midrst_wr_en", 64'(wr_en_o), 64'h3);
    checkOutput("midrst_ready", 64'(cfg_ready_o), 64'h0);
    checkOutput("midrst_busy", 64'(busy_o), 64'h0);
    rst_n = 1'b1;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
